// File: rtl/data_mem_ctrl.sv
// Byte-addressable little-endian data memory controller for the MEM stage.
// Requests use a valid/ready handshake. Loads and stores may be byte, half,
// word or double-word in size, and loads are sign- or zero-extended. An access
// that crosses a word boundary is split into two word cycles when
// ALLOW_MISALIGNED=1. Every accepted request gets exactly one response pulse.
// Ports:
//   clk, rst           clock (rising edge), asynchronous active-high reset
//   req_valid/ready    request handshake; ready is high only while idle
//   req_we             1 = store, 0 = load
//   req_size           log2 of the byte count (0 byte .. 3 double)
//   req_unsigned       zero-extend loads when 1, sign-extend when 0
//   req_addr           byte address
//   req_wdata          store data, right-aligned
//   resp_valid         one-cycle response pulse
//   resp_rdata         extended load data (0 for stores and errors)
//   resp_err           size, range or alignment error, qualified by resp_valid
module data_mem_ctrl #(
  parameter int unsigned DATA_WIDTH       = 32,
  parameter int unsigned ADDR_WIDTH       = 16,
  parameter int unsigned MEM_WORDS        = 256,
  parameter int unsigned ALLOW_MISALIGNED = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err
);

  localparam int unsigned NB    = DATA_WIDTH / 8;
  localparam int unsigned OFF_W = $clog2(NB);
  localparam int unsigned IDX_W = $clog2(MEM_WORDS);
  localparam logic [63:0] LAST_ADDR = 64'(MEM_WORDS) * 64'(NB) - 64'd1;

  typedef enum logic [1:0] {StIdle, StAcc1, StAcc2, StResp} state_e;

  state_e                  state;
  logic                    we_q, uns_q, err_q, cross_q;
  logic [3:0]              n_q;
  logic [OFF_W-1:0]        off_q;
  logic [IDX_W-1:0]        idx_q;
  logic [2*NB-1:0]         mask_q;
  logic [2*DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0]   lo_q;
  logic [DATA_WIDTH-1:0]   rd_word;

  // Zero contents at time zero only; the array is never reset.
  logic [DATA_WIDTH-1:0] mem [MEM_WORDS] = '{default: '0};

  // Request decode, used only at the accept edge.
  logic [OFF_W-1:0]        in_off;
  logic [IDX_W-1:0]        in_idx;
  logic [3:0]              in_n;
  logic [63:0]             in_last;
  logic                    in_cross, in_err;
  logic [2*NB-1:0]         in_mask;
  logic [2*DATA_WIDTH-1:0] in_wdata;

  always_comb begin
    in_off   = req_addr[OFF_W-1:0];
    in_idx   = req_addr[OFF_W +: IDX_W];
    in_n     = 4'd1 << req_size;
    in_last  = 64'(req_addr) + 64'(in_n) - 64'd1;
    in_cross = (32'(in_off) + 32'(in_n)) > NB;
    in_err   = (32'(in_n) > NB) || (in_last > LAST_ADDR) ||
               (in_cross && (ALLOW_MISALIGNED == 0));
    // Lane mask and data spread over two words: low half goes to ACC1, high half to ACC2.
    in_mask  = (2*NB)'((16'd1 << in_n) - 16'd1) << in_off;
    in_wdata = {{DATA_WIDTH{1'b0}}, req_wdata} << (8 * in_off);
  end

  // Per-cycle word access.
  logic                  acc_en;
  logic [IDX_W-1:0]      acc_idx;
  logic [NB-1:0]         acc_mask;
  logic [DATA_WIDTH-1:0] acc_data;

  always_comb begin
    acc_en = ((state == StAcc1) || (state == StAcc2)) && !err_q;
    if (state == StAcc2) begin
      acc_idx  = idx_q + IDX_W'(1);
      acc_mask = mask_q[2*NB-1:NB];
      acc_data = wdata_q[2*DATA_WIDTH-1:DATA_WIDTH];
    end else begin
      acc_idx  = idx_q;
      acc_mask = mask_q[NB-1:0];
      acc_data = wdata_q[DATA_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (acc_en) begin
      rd_word <= mem[acc_idx];
      if (we_q) begin
        for (int b = 0; b < NB; b++) begin
          if (acc_mask[b]) mem[acc_idx][8*b +: 8] <= acc_data[8*b +: 8];
        end
      end
    end
  end

  // Load assembly: lowest address is the LS byte, then extend above n bytes.
  logic [2*DATA_WIDTH-1:0] ld_wide;
  logic [DATA_WIDTH-1:0]   ld_val;
  logic                    ld_sign;

  always_comb begin
    ld_wide = cross_q ? {rd_word, lo_q} : {{DATA_WIDTH{1'b0}}, rd_word};
    ld_val  = DATA_WIDTH'(ld_wide >> (8 * off_q));
    ld_sign = 1'b0;
    for (int b = 0; b < NB; b++) begin
      if (b + 1 == int'(n_q)) ld_sign = ld_val[8*b+7];
    end
    for (int b = 0; b < NB; b++) begin
      if (b >= int'(n_q)) ld_val[8*b +: 8] = {8{ld_sign & ~uns_q}};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= StIdle;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      we_q       <= 1'b0;
      uns_q      <= 1'b0;
      err_q      <= 1'b0;
      cross_q    <= 1'b0;
      n_q        <= 4'd1;
      off_q      <= '0;
      idx_q      <= '0;
      mask_q     <= '0;
      wdata_q    <= '0;
      lo_q       <= '0;
    end else begin
      resp_valid <= 1'b0;
      unique case (state)
        StIdle: begin
          if (req_valid) begin
            we_q      <= req_we;
            uns_q     <= req_unsigned;
            err_q     <= in_err;
            cross_q   <= in_cross;
            n_q       <= in_n;
            off_q     <= in_off;
            idx_q     <= in_idx;
            mask_q    <= in_mask;
            wdata_q   <= in_wdata;
            req_ready <= 1'b0;
            state     <= StAcc1;
          end
        end
        // Errors skip the second word so they keep the aligned latency.
        StAcc1: state <= (cross_q && !err_q) ? StAcc2 : StResp;
        StAcc2: begin
          lo_q  <= rd_word;
          state <= StResp;
        end
        StResp: begin
          resp_valid <= 1'b1;
          resp_err   <= err_q;
          resp_rdata <= (err_q || we_q) ? '0 : ld_val;
          req_ready  <= 1'b1;
          state      <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
module tb_data_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_we, req_unsigned, sel;
  logic [1:0]  req_size;
  logic [15:0] req_addr;
  logic [31:0] req_wdata;

  logic        valid_a, ready_a, rv_a, err_a;
  logic        valid_b, ready_b, rv_b, err_b;
  logic [31:0] rdata_a, rdata_b;
  logic        m_ready, m_rv, m_err;
  logic [31:0] m_rdata;

  int checks = 0;
  int errors = 0;
  int ncyc   = 0;
  int last_acc = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          acc;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) ncyc <= ncyc + 1;

  assign valid_a = req_valid & ~sel;
  assign valid_b = req_valid & sel;
  assign m_ready = sel ? ready_b : ready_a;
  assign m_rv    = sel ? rv_b : rv_a;
  assign m_err   = sel ? err_b : err_a;
  assign m_rdata = sel ? rdata_b : rdata_a;

  data_mem_ctrl #(
    .DATA_WIDTH(32), .ADDR_WIDTH(16), .MEM_WORDS(256), .ALLOW_MISALIGNED(1)
  ) dut_a (
    .clk(clk), .rst(rst), .req_valid(valid_a), .req_ready(ready_a), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(rv_a), .resp_rdata(rdata_a), .resp_err(err_a)
  );

  data_mem_ctrl #(
    .DATA_WIDTH(32), .ADDR_WIDTH(16), .MEM_WORDS(256), .ALLOW_MISALIGNED(0)
  ) dut_b (
    .clk(clk), .rst(rst), .req_valid(valid_b), .req_ready(ready_b), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(rv_b), .resp_rdata(rdata_b), .resp_err(err_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One transaction: wait for ready, push expectation, then pop/compare on resp_valid.
  // Called just after a negedge; gap>0 also checks the spacing between accept edges.
  task automatic xfer(input logic s, input logic we, input logic [1:0] size, input logic uns,
                      input logic [15:0] addr, input logic [31:0] wdata,
                      input logic [31:0] e_rdata, input logic e_err, input int e_lat,
                      input logic keep, input int gap);
    exp_t e;
    int   acc;
    logic got;
    sel = s; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
    for (int i = 0; i < 20 && m_ready !== 1'b1; i++) @(negedge clk);
    chk("accept_ready", 32'(m_ready), 32'd1);
    acc = ncyc + 1;
    if (gap > 0) chk("accept_gap", 32'(acc - last_acc), 32'(gap));
    last_acc = acc;
    e.rdata = e_rdata; e.err = e_err; e.lat = e_lat; e.acc = acc;
    sb.push_back(e);
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      if (m_rv === 1'b1) got = 1'b1;
      else chk("ready_busy", 32'(m_ready), 32'd0);
    end
    if (!keep) req_valid = 1'b0;
    chk("resp_seen", 32'(got), 32'd1);
    e = sb.pop_front();
    if (got) begin
      chk("rdata", m_rdata, e.rdata);
      chk("err", 32'(m_err), 32'(e.err));
      chk("latency", 32'(ncyc - e.acc), 32'(e.lat));
      chk("ready_after_resp", 32'(m_ready), 32'd1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; req_valid = 1'b0; sel = 1'b0; req_we = 1'b0; req_size = 2'd0;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
    #12;
    chk("rst_ready_a", 32'(ready_a), 32'd1);
    chk("rst_rv_a", 32'(rv_a), 32'd0);
    chk("rst_rdata_a", rdata_a, 32'd0);
    chk("rst_err_a", 32'(err_a), 32'd0);
    chk("rst_ready_b", 32'(ready_b), 32'd1);
    chk("rst_rv_b", 32'(rv_b), 32'd0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);

    // 1: word store and load
    xfer(0, 1, 2, 0, 16'h0010, 32'hDEADBEEF, 32'h0, 0, 2, 0, 0);
    xfer(0, 0, 2, 0, 16'h0010, 32'h0, 32'hDEADBEEF, 0, 2, 0, 0);
    @(negedge clk);
    chk("resp_one_cycle", 32'(rv_a), 32'd0);

    // 2: byte store (upper wdata bits ignored), signed/unsigned byte loads
    xfer(0, 1, 0, 0, 16'h0011, 32'h12345680, 32'h0, 0, 2, 0, 0);
    xfer(0, 0, 0, 0, 16'h0011, 32'h0, 32'hFFFFFF80, 0, 2, 0, 0);
    xfer(0, 0, 0, 1, 16'h0011, 32'h0, 32'h00000080, 0, 2, 0, 0);
    xfer(0, 0, 2, 0, 16'h0010, 32'h0, 32'hDEAD80EF, 0, 2, 0, 0);

    // 3: crossing half store and loads
    xfer(0, 1, 1, 0, 16'h0013, 32'h7777A55A, 32'h0, 0, 3, 0, 0);
    xfer(0, 0, 1, 1, 16'h0013, 32'h0, 32'h0000A55A, 0, 3, 0, 0);
    xfer(0, 0, 1, 0, 16'h0013, 32'h0, 32'hFFFFA55A, 0, 3, 0, 0);
    xfer(0, 0, 0, 1, 16'h0013, 32'h0, 32'h0000005A, 0, 2, 0, 0);
    xfer(0, 0, 0, 0, 16'h0014, 32'h0, 32'hFFFFFFA5, 0, 2, 0, 0);
    xfer(0, 0, 2, 0, 16'h0010, 32'h0, 32'h5AAD80EF, 0, 2, 0, 0);
    xfer(0, 0, 2, 0, 16'h0014, 32'h0, 32'h000000A5, 0, 2, 0, 0);
    xfer(0, 0, 1, 1, 16'h0012, 32'h0, 32'h00005AAD, 0, 2, 0, 0);
    xfer(0, 0, 2, 0, 16'h0011, 32'h0, 32'hA55AAD80, 0, 3, 0, 0);

    // 4: errors; misaligned disallowed on dut_b, range/size on both
    xfer(1, 0, 2, 0, 16'h0002, 32'h0, 32'h0, 1, 2, 0, 0);
    xfer(1, 0, 2, 0, 16'h03FE, 32'h0, 32'h0, 1, 2, 0, 0);
    xfer(1, 1, 2, 0, 16'h03FC, 32'hCAFEF00D, 32'h0, 0, 2, 0, 0);
    xfer(1, 0, 2, 0, 16'h03FC, 32'h0, 32'hCAFEF00D, 0, 2, 0, 0);
    xfer(1, 0, 1, 0, 16'h0003, 32'h0, 32'h0, 1, 2, 0, 0);
    xfer(0, 0, 2, 0, 16'h03FE, 32'h0, 32'h0, 1, 2, 0, 0);
    xfer(0, 0, 3, 0, 16'h0000, 32'h0, 32'h0, 1, 2, 0, 0);
    xfer(0, 0, 0, 0, 16'h0400, 32'h0, 32'h0, 1, 2, 0, 0);
    xfer(0, 1, 2, 0, 16'h03FE, 32'h11111111, 32'h0, 1, 2, 0, 0);
    xfer(0, 0, 1, 1, 16'h03FE, 32'h0, 32'h0, 0, 2, 0, 0);

    // 5: back-to-back aligned loads with req_valid held high
    xfer(0, 0, 2, 0, 16'h0010, 32'h0, 32'h5AAD80EF, 0, 2, 1, 0);
    xfer(0, 0, 2, 0, 16'h0014, 32'h0, 32'h000000A5, 0, 2, 1, 3);
    xfer(0, 0, 2, 0, 16'h0010, 32'h0, 32'h5AAD80EF, 0, 2, 1, 3);
    xfer(0, 0, 2, 0, 16'h0014, 32'h0, 32'h000000A5, 0, 2, 0, 3);

    // 6: reset during ACC2 of a crossing store
    xfer(0, 1, 2, 0, 16'h0010, 32'h11223344, 32'h0, 0, 2, 0, 0);
    xfer(0, 1, 2, 0, 16'h0014, 32'h55667788, 32'h0, 0, 2, 0, 0);
    sel = 1'b0; req_we = 1'b1; req_size = 2'd1; req_unsigned = 1'b0;
    req_addr = 16'h0013; req_wdata = 32'h0000A55A;
    chk("pre_abort_ready", 32'(ready_a), 32'd1);
    req_valid = 1'b1;
    @(posedge clk); #1 req_valid = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    #1;
    chk("abort_ready", 32'(ready_a), 32'd1);
    chk("abort_rv", 32'(rv_a), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_no_resp", 32'(rv_a), 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);
    xfer(0, 0, 2, 0, 16'h0010, 32'h0, 32'h5A223344, 0, 2, 0, 0);
    xfer(0, 0, 2, 0, 16'h0014, 32'h0, 32'h55667788, 0, 2, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
